// File: rtl/program_mem.sv
// Instruction memory: fills itself with NOP words after reset, serves word fetches, and accepts program loads.
// Latency: a fetch returns its data one cycle after it is accepted; one fetch per cycle is sustained.
// Backpressure: a response not taken by the consumer is held stable, and no new fetch is accepted until it is taken.
module program_mem #(
  parameter int          DEPTH          = 256,
  parameter logic [31:0] NOP_WORD       = 32'h00000013,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr_bus,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] data_bus,
  output logic [1:0]  rsp_fault,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        init_done
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
  localparam logic [0:0]  ST_INIT   = 1'b0;
  localparam logic [0:0]  ST_IDLE   = 1'b1;
  localparam logic [0:0]  ST_RESET  = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;

  // Storage is deliberately not reset, so it survives reset when the clear pass is disabled.
  logic [31:0]   mem [DEPTH];
  logic [0:0]    state;
  logic [AW-1:0] init_idx;

  logic          accept;
  logic [1:0]    fetch_fault;
  logic          load_ok;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_dat;

  assign init_done = (state == ST_IDLE);
  assign req_ready = (state == ST_IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Fetch faults: bit0 misaligned byte offset, bit1 word index beyond the array.
  assign fetch_fault[0] = (addr_bus[1:0] != 2'b00);
  assign fetch_fault[1] = (addr_bus[31:2] >= DEPTH_W);

  assign load_ok = load_en && (state == ST_IDLE) && (load_addr[1:0] == 2'b00)
                   && (load_addr[31:2] < DEPTH_W);

  // Single write port, shared between the clear pass and program loads.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_dat = NOP_WORD;
    if (state == ST_INIT) begin
      wr_en  = 1'b1;
      wr_idx = init_idx;
      wr_dat = NOP_WORD;
    end else if (load_ok) begin
      wr_en  = 1'b1;
      wr_idx = load_addr[AW+1:2];
      wr_dat = load_data;
    end
  end

  // Memory write; a same-edge read below sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  // Clear-pass sequencer: one word per cycle, IDLE after the last index is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RESET;
      init_idx <= '0;
    end else if (state == ST_INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == AW'(DEPTH - 1)) begin
        state <= ST_IDLE;
      end
    end
  end

  // Response register: load on accept, drop on consume, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      data_bus  <= NOP_WORD;
      rsp_fault <= 2'b00;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_fault <= fetch_fault;
      data_bus  <= (fetch_fault != 2'b00) ? NOP_WORD : mem[addr_bus[AW+1:2]];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_program_mem.sv
// Directed bench for program_mem at DEPTH=16 with the clear pass enabled.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_program_mem;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr_bus = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] data_bus;
  logic [1:0]  rsp_fault;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        init_done;

  int vectors = 0;
  int errors  = 0;

  program_mem #(.DEPTH(16), .NOP_WORD(NOP), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .addr_bus(addr_bus), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .data_bus(data_bus), .rsp_fault(rsp_fault), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // One accepted fetch with rsp_ready high; returns at the falling edge after the accept.
  task automatic fetch(input logic [31:0] a);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    addr_bus  = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic test_reset;
    int cnt;
    rst_n = 1'b0;
    req_valid = 1'b1;
    addr_bus = 32'h0;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    vectors++; if (data_bus !== NOP) begin errors++; $display("FAIL reset_data got %h exp %h", data_bus, NOP); end
    vectors++; if (rsp_fault !== 2'b00) begin errors++; $display("FAIL reset_fault got %b exp 00", rsp_fault); end
    vectors++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
    vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (init_done === 1'b1) break;
      if (cnt == 8) begin
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL init_req_ready got %b exp 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL init_rsp_valid got %b exp 0", rsp_valid); end
      end
    end
    req_valid = 1'b0;
    vectors++; if (cnt != 16) begin errors++; $display("FAIL init_cycles got %0d exp 16", cnt); end
  endtask

  task automatic test_fetch_nop;
    fetch(32'h3C);
    vectors++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL nop_valid got %b exp 1", rsp_valid); end
    vectors++; if (data_bus !== NOP) begin errors++; $display("FAIL nop_data got %h exp %h", data_bus, NOP); end
    vectors++; if (rsp_fault !== 2'b00) begin errors++; $display("FAIL nop_fault got %b exp 00", rsp_fault); end
  endtask

  task automatic test_load;
    load(32'h0, 32'h00300093);
    fetch(32'h0);
    vectors++; if (data_bus !== 32'h00300093) begin errors++; $display("FAIL load_data got %h exp 00300093", data_bus); end
    vectors++; if (rsp_fault !== 2'b00) begin errors++; $display("FAIL load_fault got %b exp 00", rsp_fault); end
    // Misaligned and out-of-range loads must be dropped (0x40 would alias index 0 if not).
    load(32'h6, 32'hAAAA5555);
    load(32'h40, 32'h5555AAAA);
    fetch(32'h4);
    vectors++; if (data_bus !== NOP) begin errors++; $display("FAIL drop_misaligned got %h exp %h", data_bus, NOP); end
    fetch(32'h0);
    vectors++; if (data_bus !== 32'h00300093) begin errors++; $display("FAIL drop_range got %h exp 00300093", data_bus); end
  endtask

  task automatic test_faults;
    fetch(32'h2);
    vectors++; if (rsp_fault !== 2'b01) begin errors++; $display("FAIL fault_misaligned got %b exp 01", rsp_fault); end
    vectors++; if (data_bus !== NOP) begin errors++; $display("FAIL fault_misaligned_data got %h exp %h", data_bus, NOP); end
    fetch(32'h40);
    vectors++; if (rsp_fault !== 2'b10) begin errors++; $display("FAIL fault_range got %b exp 10", rsp_fault); end
    vectors++; if (data_bus !== NOP) begin errors++; $display("FAIL fault_range_data got %h exp %h", data_bus, NOP); end
    fetch(32'h41);
    vectors++; if (rsp_fault !== 2'b11) begin errors++; $display("FAIL fault_both got %b exp 11", rsp_fault); end
  endtask

  task automatic test_back_to_back;
    load(32'h4, 32'h11111111);
    load(32'h8, 32'h22222222);
    rsp_ready = 1'b1;
    req_valid = 1'b1; addr_bus = 32'h0;
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b1 || data_bus !== 32'h00300093) begin errors++; $display("FAIL b2b_0 got %b/%h exp 1/00300093", rsp_valid, data_bus); end
    addr_bus = 32'h4;
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b1 || data_bus !== 32'h11111111) begin errors++; $display("FAIL b2b_1 got %b/%h exp 1/11111111", rsp_valid, data_bus); end
    addr_bus = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++; if (rsp_valid !== 1'b1 || data_bus !== 32'h22222222) begin errors++; $display("FAIL b2b_2 got %b/%h exp 1/22222222", rsp_valid, data_bus); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", rsp_valid); end
    // Stall: hold a response for three cycles while another fetch and a load are pending.
    rsp_ready = 1'b0;
    req_valid = 1'b1; addr_bus = 32'h4;
    @(negedge clk);
    addr_bus = 32'h8;
    load_en = 1'b1; load_addr = 32'h4; load_data = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d] got %b exp 0", i, req_ready); end
      vectors++; if (rsp_valid !== 1'b1 || data_bus !== 32'h11111111 || rsp_fault !== 2'b00) begin errors++; $display("FAIL stall_hold[%0d] got %b/%h/%b exp 1/11111111/00", i, rsp_valid, data_bus, rsp_fault); end
      @(negedge clk);
      load_en = 1'b0;
    end
    rsp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got %b exp 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    vectors++; if (rsp_valid !== 1'b1 || data_bus !== 32'h22222222) begin errors++; $display("FAIL consume_and_accept got %b/%h exp 1/22222222", rsp_valid, data_bus); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL consume_fall got %b exp 0", rsp_valid); end
    fetch(32'h4);
    vectors++; if (data_bus !== 32'h33333333) begin errors++; $display("FAIL stall_load got %h exp 33333333", data_bus); end
  endtask

  task automatic test_same_edge;
    rsp_ready = 1'b1;
    load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEADBEEF;
    req_valid = 1'b1; addr_bus = 32'h8;
    @(negedge clk);
    load_en = 1'b0;
    vectors++; if (data_bus !== 32'h22222222) begin errors++; $display("FAIL same_edge_old got %h exp 22222222", data_bus); end
    @(negedge clk);
    req_valid = 1'b0;
    vectors++; if (data_bus !== 32'hDEADBEEF) begin errors++; $display("FAIL same_edge_new got %h exp deadbeef", data_bus); end
  endtask

  task automatic test_reset_pending;
    int cnt;
    int stale;
    rsp_ready = 1'b0;
    req_valid = 1'b1; addr_bus = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL pend_valid got %b exp 1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL async_clear got %b exp 0", rsp_valid); end
    vectors++; if (init_done !== 1'b0) begin errors++; $display("FAIL async_init_done got %b exp 0", init_done); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    cnt = 0; stale = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (rsp_valid !== 1'b0) stale++;
      if (init_done === 1'b1) break;
    end
    vectors++; if (cnt != 16) begin errors++; $display("FAIL reinit_cycles got %0d exp 16", cnt); end
    vectors++; if (stale != 0) begin errors++; $display("FAIL stale_rsp got %0d cycles exp 0", stale); end
    fetch(32'h8);
    vectors++; if (data_bus !== NOP) begin errors++; $display("FAIL reinit_cleared got %h exp %h", data_bus, NOP); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_fetch_nop;
    test_load;
    test_faults;
    test_back_to_back;
    test_same_edge;
    test_reset_pending;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/program_mem.md
PROGRAM_MEM -- requirements
Module: program_mem

Interface
REQ-001 Parameter DEPTH, default 256: memory size in 32-bit words; SHALL be a power of two >= 4.
REQ-002 Parameter NOP_WORD, default 32'h00000013: fill/fault word (ADDI x0,x0,0).
REQ-003 Parameter CLEAR_ON_RESET, default 1: when 1, the block SHALL fill all words with NOP_WORD after reset.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  fetch request.
REQ-008 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-009 addr_bus  in  32  byte address of the fetch.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready.
REQ-012 data_bus  out  32  fetched instruction word.
REQ-013 rsp_fault  out  2  bit0 = misaligned, bit1 = out of range.
REQ-014 load_en  in  1  write strobe for program loading.
REQ-015 load_addr  in  32  byte address of the load.
REQ-016 load_data  in  32  word to write.
REQ-017 init_done  out  1  high when the block is in IDLE.

Function
REQ-018 FSM states SHALL be INIT and IDLE; reset SHALL enter INIT if CLEAR_ON_RESET=1, else IDLE.
REQ-019 INIT SHALL write NOP_WORD to index 0,1,...,DEPTH-1, one word per cycle, then enter IDLE; INIT SHALL last exactly DEPTH cycles.
REQ-020 In INIT: req_ready=0, load_en ignored, init_done=0.
REQ-021 Word index SHALL be addr_bus[31:2]; byte offset addr_bus[1:0] SHALL NOT index memory.
REQ-022 req_ready SHALL equal (state==IDLE) && (!rsp_valid || rsp_ready), combinationally.
REQ-023 Read latency SHALL be 1 cycle: accept at edge N -> rsp_valid=1 with data after edge N.
REQ-024 With rsp_ready held 1, one request per cycle SHALL be accepted (full throughput, no bubbles).
REQ-025 While rsp_valid && !rsp_ready, data_bus and rsp_fault SHALL hold stable and no new request SHALL be accepted.
REQ-026 rsp_valid SHALL fall after a consume edge unless a new request is accepted on the same edge.
REQ-027 addr_bus[1:0]!=0 -> rsp_fault[0]=1, data_bus=NOP_WORD.
REQ-028 addr_bus[31:2] >= DEPTH -> rsp_fault[1]=1, data_bus=NOP_WORD; both bits may be set together.
REQ-029 load_en in IDLE, aligned and in range -> mem[load_addr[31:2]] = load_data at the edge; otherwise the load SHALL be silently dropped.
REQ-030 A load and an accepted read of the same word on one edge: the read SHALL return the old word; a read accepted on the next edge SHALL return the new word.
REQ-031 Loads SHALL NOT affect req_ready, rsp_valid, or a held response.

Reset
REQ-032 During reset: rsp_valid=0, data_bus=NOP_WORD, rsp_fault=0, init_done=!CLEAR_ON_RESET, req_ready=!CLEAR_ON_RESET.
REQ-033 Reset asserted mid-INIT or with a pending response SHALL discard the response and restart per REQ-018.
REQ-034 With CLEAR_ON_RESET=0, memory contents SHALL be preserved across reset.

Verification (DEPTH=16)
REQ-035 Release reset, CLEAR_ON_RESET=1 -> init_done rises after exactly 16 cycles; a fetch of 0x3C returns 0x00000013, fault=0.
REQ-036 Load 0x00300093 at 0x0, then fetch 0x0 -> data_bus=0x00300093 one cycle after accept, fault=0.
REQ-037 Fetch 0x02 -> fault=2'b01, data_bus=NOP_WORD; fetch 0x40 -> fault=2'b10; fetch 0x41 -> fault=2'b11.
REQ-038 Back-to-back fetches 0x0,0x4,0x8 with rsp_ready=1 -> three consecutive rsp_valid cycles in order; rsp_ready=0 for 3 cycles -> data_bus stable, req_ready=0.
REQ-039 Same-edge load of 0xDEADBEEF and fetch of 0x8 -> old word returned; next fetch of 0x8 -> 0xDEADBEEF.
REQ-040 Reset asserted with rsp_valid=1 -> rsp_valid=0 immediately (asynchronously), INIT restarts, and no stale response appears after reset is released.
